// File: rtl/miniproc_pkg.sv
// Shared encodings for the fetch/data memory arbiter: access sizes, FSM states, port owners.
package miniproc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {IDLE, ACC} state_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory port seen by mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wen;
  logic              mem_rd;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_wdata, mem_wen, mem_rd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_wdata, mem_wen, mem_rd
  );
endinterface

// File: rtl/mem_lane_gen.sv
// Combinational store-lane decoder: active-low byte enables, replicated write data, misalignment flag.
module mem_lane_gen
  import miniproc_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    wen_o        = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        wen_o   = ~(4'b0001 << addr_i);
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        if (addr_i[0]) begin
          misaligned_o = 1'b1;
        end else begin
          wen_o = addr_i[1] ? 4'b0011 : 4'b1100;
        end
      end
      SZ_WORD: begin
        if (addr_i != 2'd0) begin
          misaligned_o = 1'b1;
        end else begin
          wen_o = 4'b0000;
        end
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port: combinational grant in IDLE, one ACC cycle, rvalid the cycle after.
// Contention goes to the data port unless ARB_RR_EN is defined, which alternates between ports.
module mem_arbiter
  import miniproc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              d_err_q, d_err_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              i_gnt_c, d_gnt_c, mem_rd_c;
  logic [3:0]        mem_wen_c;
  logic              win_dport;
  logic [3:0]        lane_wen;
  logic [31:0]       lane_wdata;
  logic              lane_mis;
  logic [31:0]       rsp_data;

  mem_lane_gen u_lane (
    .size_i       (size_q),
    .addr_i       (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .wen_o        (lane_wen),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_mis)
  );

`ifdef ARB_RR_EN
  owner_t last_q, last_d;

  // Contention goes to whichever port was not granted last.
  assign win_dport = bus.d_req && (!bus.i_req || last_q == OWN_I);

  always_comb begin
    last_d = last_q;
    if (d_gnt_c) begin
      last_d = OWN_D;
    end else if (i_gnt_c) begin
      last_d = OWN_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign win_dport = bus.d_req;
`endif

  assign rsp_data = we_q ? 32'd0 : bus.mem_rdata;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    d_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_gnt_c    = 1'b0;
    d_gnt_c    = 1'b0;
    mem_rd_c   = 1'b0;
    mem_wen_c  = 4'b1111;
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held, since they are combinational.
        if (!rst && (bus.i_req || bus.d_req)) begin
          state_d = ACC;
          if (win_dport) begin
            d_gnt_c = 1'b1;
            owner_d = OWN_D;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            size_d  = bus.d_size;
            wdata_d = bus.d_wdata;
          end else begin
            i_gnt_c = 1'b1;
            owner_d = OWN_I;
            addr_d  = bus.i_addr;
            we_d    = 1'b0;
            size_d  = SZ_WORD;
            wdata_d = 32'd0;
          end
        end
      end
      ACC: begin
        state_d = IDLE;
        if (we_q) begin
          mem_wen_c = lane_wen;
        end else begin
          mem_rd_c = 1'b1;
        end
        if (owner_q == OWN_D) begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = rsp_data;
          d_err_d    = we_q && lane_mis;
        end else begin
          i_rvalid_d = 1'b1;
          i_rdata_d  = rsp_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      wdata_q    <= 32'd0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_gnt     = i_gnt_c;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = lane_wdata;
  assign bus.mem_wen   = mem_wen_c;
  assign bus.mem_rd    = mem_rd_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, response scoreboard and per-scenario directed tasks.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   checks;
  int   errors;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  typedef struct packed {
    logic        port_d;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  widx;
    logic [3:0]  wmask;
    logic [31:0] wval;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wen;
    logic [31:0] wdo;
    logic        err;
  } st_t;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] pat(int i);
    return (i == 2) ? 32'h00110113 : 32'h10000000 + 32'(i) * 32'd4;
  endfunction

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (!bus.mem_wen[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'd0;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;
  endtask

  task automatic sb_monitor();
    exp_t        e;
    exp_t        n;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (bus.i_gnt && bus.d_gnt) begin
          errors++;
          $display("FAIL gnt_exclusive: i_gnt=%b d_gnt=%b, expected at most one", bus.i_gnt, bus.d_gnt);
        end
        if (bus.i_rvalid || bus.d_rvalid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: i_rvalid=%b d_rvalid=%b with nothing outstanding",
                     bus.i_rvalid, bus.d_rvalid);
          end else begin
            e   = sb.pop_front();
            act = e.port_d ? bus.d_rdata : bus.i_rdata;
            if (bus.d_rvalid !== e.port_d || bus.i_rvalid !== !e.port_d || act !== e.rdata ||
                bus.d_err !== (e.port_d & e.err)) begin
              errors++;
              $display("FAIL sb_response: d_rvalid=%b rdata=%h err=%b, expected d_port=%b rdata=%h err=%b",
                       bus.d_rvalid, act, bus.d_err, e.port_d, e.rdata, e.err);
            end
            for (int b = 0; b < 4; b++)
              if (e.wmask[b]) ref_mem[e.widx][8*b +: 8] = e.wval[8*b +: 8];
          end
        end
        if (bus.i_gnt) begin
          n        = '0;
          n.widx   = bus.i_addr[9:2];
          n.rdata  = ref_mem[bus.i_addr[9:2]];
          sb.push_back(n);
        end
        if (bus.d_gnt) begin
          n        = '0;
          n.port_d = 1'b1;
          n.widx   = bus.d_addr[9:2];
          a        = bus.d_addr[1:0];
          wd       = bus.d_wdata;
          if (bus.d_we) begin
            if (bus.d_size == 2'd3 || (bus.d_size == 2'd1 && a[0]) || (bus.d_size == 2'd2 && a != 2'd0)) begin
              n.err = 1'b1;
            end else begin
              for (int b = 0; b < 4; b++) begin
                case (bus.d_size)
                  2'd0: if (b == int'(a)) begin
                    n.wmask[b] = 1'b1; n.wval[8*b +: 8] = wd[7:0];
                  end
                  2'd1: if (b / 2 == int'(a[1])) begin
                    n.wmask[b] = 1'b1; n.wval[8*b +: 8] = wd[8*(b%2) +: 8];
                  end
                  default: begin
                    n.wmask[b] = 1'b1; n.wval[8*b +: 8] = wd[8*b +: 8];
                  end
                endcase
              end
            end
          end else begin
            n.rdata = ref_mem[bus.d_addr[9:2]];
          end
          sb.push_back(n);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: i_gnt=%b d_gnt=%b, expected 0 0", bus.i_gnt, bus.d_gnt);
    end
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.d_err !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid: i=%b d=%b err=%b, expected 0", bus.i_rvalid, bus.d_rvalid, bus.d_err);
    end
    checks++;
    if (bus.mem_wen !== 4'b1111 || bus.mem_rd !== 1'b0) begin
      errors++; $display("FAIL reset_mem_ctl: wen=%b rd=%b, expected 1111 0", bus.mem_wen, bus.mem_rd);
    end
    checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h, expected 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.i_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: i=%h d=%h, expected 0", bus.i_rdata, bus.d_rdata);
    end
    idle_inputs();
    tick();
    mem_init = 1'b0;
    rst      = 1'b0;
    tick();
  endtask

  task automatic test_word_read();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      errors++; $display("FAIL read_gnt: i_gnt=%b d_gnt=%b, expected 1 0", bus.i_gnt, bus.d_gnt);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_wen !== 4'b1111 || bus.mem_addr !== 32'h8 || bus.i_gnt !== 1'b0) begin
      errors++; $display("FAIL read_acc: rd=%b wen=%b addr=%h gnt=%b, expected 1 1111 8 0",
                         bus.mem_rd, bus.mem_wen, bus.mem_addr, bus.i_gnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h00110113) begin
      errors++; $display("FAIL read_rsp: rvalid=%b rdata=%h, expected 1 00110113", bus.i_rvalid, bus.i_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h00110113) begin
      errors++; $display("FAIL read_hold: rvalid=%b rdata=%h, expected 0 00110113", bus.i_rvalid, bus.i_rdata);
    end
    tick();
  endtask

  task automatic test_stores();
    st_t tbl [8];
    tbl[0] = '{2'd0, 32'h3FE, 32'h000000AB, 4'b1011, 32'hABABABAB, 1'b0};
    tbl[1] = '{2'd1, 32'h100, 32'h00001234, 4'b1100, 32'h12341234, 1'b0};
    tbl[2] = '{2'd1, 32'h102, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF, 1'b0};
    tbl[3] = '{2'd0, 32'h101, 32'h000000CD, 4'b1101, 32'hCDCDCDCD, 1'b0};
    tbl[4] = '{2'd2, 32'h104, 32'hCAFEF00D, 4'b0000, 32'hCAFEF00D, 1'b0};
    tbl[5] = '{2'd1, 32'h101, 32'h00005555, 4'b1111, 32'h0, 1'b1};
    tbl[6] = '{2'd2, 32'h3FD, 32'h11223344, 4'b1111, 32'h0, 1'b1};
    tbl[7] = '{2'd3, 32'h108, 32'h99887766, 4'b1111, 32'h0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_size  = tbl[k].sz;
      bus.d_addr  = tbl[k].addr;
      bus.d_wdata = tbl[k].wd;
      @(negedge clk);
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.mem_wen !== 4'b1111) begin
        errors++; $display("FAIL store%0d_gnt: gnt=%b wen=%b, expected 1 1111", k, bus.d_gnt, bus.mem_wen);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.mem_wen !== tbl[k].wen || bus.mem_rd !== 1'b0 || bus.mem_addr !== tbl[k].addr) begin
        errors++; $display("FAIL store%0d_acc: wen=%b rd=%b addr=%h, expected %b 0 %h",
                           k, bus.mem_wen, bus.mem_rd, bus.mem_addr, tbl[k].wen, tbl[k].addr);
      end
      if (!tbl[k].err) begin
        checks++;
        if (bus.mem_wdata !== tbl[k].wdo) begin
          errors++; $display("FAIL store%0d_wdata: %h, expected %h", k, bus.mem_wdata, tbl[k].wdo);
        end
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_err !== tbl[k].err || bus.d_rdata !== 32'd0 || bus.mem_wen !== 4'b1111) begin
        errors++; $display("FAIL store%0d_rsp: rvalid=%b err=%b rdata=%h wen=%b, expected 1 %b 0 1111",
                           k, bus.d_rvalid, bus.d_err, bus.d_rdata, bus.mem_wen, tbl[k].err);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_size  = 2'd2;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'h55AA55AA;
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_store_gnt: %b, expected 1", bus.d_gnt);
    end
    tick();
    idle_inputs();
    tick();
    bus.d_req  = 1'b1;
    bus.d_size = 2'd2;
    bus.d_addr = 32'h200;
    @(negedge clk);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_same_cycle: rvalid=%b gnt=%b, expected 1 1", bus.d_rvalid, bus.d_gnt);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h200) begin
      errors++; $display("FAIL b2b_load_acc: rd=%b addr=%h, expected 1 200", bus.mem_rd, bus.mem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h55AA55AA) begin
      errors++; $display("FAIL b2b_load_rsp: rvalid=%b rdata=%h, expected 1 55aa55aa", bus.d_rvalid, bus.d_rdata);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] addrs [3];
    logic        exp_g;
    logic        exp_v;
    int          ng;
    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    addrs[2] = 32'h8;
    ng = 0;
    for (int c = 0; c < 9; c++) begin
      if (ng < 3) begin
        bus.i_req  = 1'b1;
        bus.i_addr = addrs[ng];
      end else begin
        bus.i_req = 1'b0;
      end
      @(negedge clk);
      exp_g = (c == 0 || c == 2 || c == 4);
      exp_v = (c == 2 || c == 4 || c == 6);
      checks++;
      if (bus.i_gnt !== exp_g || bus.i_rvalid !== exp_v) begin
        errors++; $display("FAIL stream_c%0d: gnt=%b rvalid=%b, expected %b %b", c, bus.i_gnt, bus.i_rvalid, exp_g, exp_v);
      end
      if (c == 6) begin
        checks++;
        if (bus.i_rdata !== 32'h00110113) begin
          errors++; $display("FAIL stream_last_data: %h, expected 00110113", bus.i_rdata);
        end
      end
      if (bus.i_gnt) ng++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    int got [3];
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_size = 2'd2;
    bus.d_addr = 32'h20;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (bus.d_gnt) begin
        got[n] = 1; n++;
      end else if (bus.i_gnt) begin
        got[n] = 0; n++;
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL contention_count: %0d grants, expected 3", n);
    end else begin
`ifdef ARB_RR_EN
      checks++;
      if (got[0] != 1 || got[1] != 0 || got[2] != 1) begin
        errors++; $display("FAIL contention_order: %0d%0d%0d (1=D), expected 101", got[0], got[1], got[2]);
      end
`else
      checks++;
      if (got[0] != 1 || got[1] != 1 || got[2] != 1) begin
        errors++; $display("FAIL contention_order: %0d%0d%0d (1=D), expected 111", got[0], got[1], got[2]);
      end
`endif
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_op();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_size  = 2'd2;
    bus.d_addr  = 32'h3FC;
    bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt: %b, expected 1", bus.d_gnt);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.mem_wen !== 4'b0000) begin
      errors++; $display("FAIL rstmid_acc_wen: %b, expected 0000", bus.mem_wen);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (bus.mem_wen !== 4'b1111) begin
      errors++; $display("FAIL rstmid_abort_wen: %b, expected 1111", bus.mem_wen);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.d_rvalid !== 1'b0 || bus.i_rvalid !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_rvalid_c%0d: d=%b i=%b, expected 0 0", c, bus.d_rvalid, bus.i_rvalid);
      end
      tick();
    end
    checks++;
    if (mem[255] !== ref_mem[255]) begin
      errors++; $display("FAIL rstmid_mem: word255=%h, expected %h", mem[255], ref_mem[255]);
    end
  endtask

  task automatic test_final();
    int diff;
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drained: %0d outstanding, expected 0", sb.size());
    end
    diff = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) diff++;
    checks++;
    if (diff != 0) begin
      errors++; $display("FAIL mem_image: %0d words differ, expected 0", diff);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mem_init = 1'b1;
    rst      = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    fork
      sb_monitor();
    join_none
    test_reset();
    test_word_read();
    test_stores();
    test_back_to_back();
    test_stream();
    test_contention();
    test_reset_mid_op();
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of all address ports.
REQ-002 One clock, clk; reset is rst, asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 i_req  in  1  instruction fetch request; i_addr  in  ADDR_W  fetch address.
REQ-006 i_gnt  out  1  fetch accepted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  32  fetch word.
REQ-007 d_req  in  1  data request; d_we  in  1  1=store; d_size  in  2  0=byte, 1=half, 2=word; d_addr  in  ADDR_W; d_wdata  in  32 (data in low bits).
REQ-008 d_gnt  out  1; d_rvalid  out  1; d_rdata  out  32; d_err  out  1  misaligned store rejected.
REQ-009 mem_addr  out  ADDR_W; mem_wdata  out  32; mem_wen  out  4  active-low byte-lane write enables; mem_rd  out  1; mem_rdata  in  32  combinational read data.

Function
REQ-010 FSM states: IDLE, ACC; at most one memory access in flight.
REQ-011 In IDLE with any request, the arbiter SHALL pick one winner, assert its gnt combinationally that cycle, register addr/we/size/wdata/owner, and go to ACC.
REQ-012 In IDLE with no request: stay in IDLE, no gnt, mem_wen=4'b1111, mem_rd=0.
REQ-013 In ACC: mem_addr = registered address; read -> mem_rd=1, mem_wen=4'b1111, mem_rdata captured at the clock edge; store -> mem_rd=0, mem_wen per REQ-015 for exactly one cycle; next state is IDLE.
REQ-014 Response: owner's rvalid pulses one cycle in the cycle after ACC, with rdata = captured word (reads) or 0 (stores); rdata holds its value until the next response for that port.
REQ-015 Store lanes (active-low): byte -> lane addr[1:0] low; half at addr[1]=0 -> 4'b1100, at addr[1]=1 -> 4'b0011; word -> 4'b0000.
REQ-016 mem_wdata: byte -> d_wdata[7:0] replicated 4x; half -> d_wdata[15:0] replicated 2x; word -> d_wdata unchanged.
REQ-017 Misaligned store (half with addr[0]=1, word with addr[1:0]!=0, or size=3): mem_wen stays 4'b1111 in ACC; d_err pulses together with d_rvalid.
REQ-018 Loads ignore alignment; the full word at addr>>2 is returned, and lane extraction is the core's job.
REQ-019 Contention (i_req and d_req both high in IDLE) is resolved per REQ-023.
REQ-020 Requesters hold req/addr/data until gnt; a request dropped before gnt is discarded without side effects.
REQ-021 Back-to-back: a request present in the IDLE cycle that carries an rvalid pulse SHALL be granted in that same cycle, giving one access per 2 cycles sustained.
REQ-022 i_gnt and d_gnt are never high in the same cycle, and neither is high in ACC.

Reset
REQ-023 Arbitration: without ARB_RR_EN, the data port always wins contention; with it, see REQ-029.
REQ-024 While rst=1, asynchronously: state=IDLE, gnt/rvalid/d_err=0, mem_wen=4'b1111, mem_rd=0, mem_addr=0, mem_wdata=0, i_rdata=d_rdata=0.
REQ-025 Reset during ACC aborts the access: no write occurs after rst rises and no rvalid is issued for it.
REQ-026 The round-robin last-owner flag resets to "fetch", so the first contention after reset grants the data port.

Configuration
REQ-027 Macro ARB_RR_EN selects the contention policy.
REQ-028 Without ARB_RR_EN: fixed priority, data over fetch; no last-owner register exists.
REQ-029 With ARB_RR_EN: on contention, grant the port not granted last; the last-owner flag updates on every grant, including uncontended ones.

Structure
REQ-030 Package miniproc_pkg holds the size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), the state typedef (IDLE, ACC) and the owner typedef (OWN_I, OWN_D).
REQ-031 One sub-module, mem_lane_gen, SHALL be purely combinational: it maps (size, addr[1:0], wdata) to (wen, wdata, misaligned).

Verification
REQ-032 Word read: i_req=1, i_addr=0x8, with mem word2=0x00110113 -> i_gnt on cycle 0, mem_rd on cycle 1, i_rvalid with i_rdata=0x00110113 on cycle 2.
REQ-033 Byte store: d_we=1, size=byte, addr=0x3FE, wdata=0xAB -> mem_wen=4'b1011 and mem_wdata=0xABABABAB for one cycle; d_rvalid next cycle; d_err=0.
REQ-034 Contention: both requests held for 3 grants -> fixed build: D,D,D (fetch starved); ARB_RR_EN build: D,I,D.
REQ-035 Misaligned word store at 0x3FD -> mem_wen stays 4'b1111 throughout; d_rvalid=1 and d_err=1 in the same cycle.
REQ-036 Reset mid-op: assert rst in ACC of a word store to 0x3FC -> mem_wen goes to 4'b1111 immediately, the memory word is unchanged, and no rvalid follows.
REQ-037 Streaming fetches: i_req held high with addresses 0,4,8 -> grants on cycles 0,2,4 and rvalid on cycles 2,4,6, in order.
